// File: rtl/integrator_fifo_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : integrator_fifo_scheduler
// Purpose  : Serialises sample-sum bursts into FIFO writes and gathers FIFO
//            reads back into a parallel chunk. Define FIFO_SCHED_OCCUPANCY_EN
//            to add the occupancy / peak_occupancy counters.
// Revision : 1.0 - initial release
// =============================================================================
module integrator_fifo_scheduler #(
    parameter int CHANNELS     = 8,
    parameter int DATA_WIDTH   = 36,
    parameter int READ_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           push_req,
    input  logic [CHANNELS*DATA_WIDTH-1:0] push_data,
    input  logic                           pop_req,
    output logic [CHANNELS*DATA_WIDTH-1:0] pop_data,
    output logic                           pop_valid,
    output logic                           fifo_wr_en,
    output logic [DATA_WIDTH-1:0]          fifo_din,
    input  logic                           fifo_full,
    output logic                           fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]          fifo_dout,
    input  logic                           fifo_empty,
    output logic                           busy,
    output logic                           overrun,
    output logic                           underflow
`ifdef FIFO_SCHED_OCCUPANCY_EN
    ,
    output logic [15:0]                    occupancy,
    output logic [15:0]                    peak_occupancy
`endif
);

    localparam int                 c_IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(CHANNELS - 1);
    localparam logic [1:0]         c_DRAIN_LAST = 2'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PUSH  = 2'd1,
        S_POP   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shadow    [CHANNELS];
    logic [DATA_WIDTH-1:0] r_pop_words [CHANNELS];
    logic [c_IDX_W-1:0]    r_idx;
    logic [1:0]            r_drain_cnt;
    logic [CHANNELS-1:0]   r_zero_mask;
    logic                  r_tag_vld [READ_LATENCY];
    logic [c_IDX_W-1:0]    r_tag_idx [READ_LATENCY];
    logic                  r_push_pending;
    logic                  r_pop_pending;
    logic                  r_pop_valid;
    logic                  r_overrun;
    logic                  r_underflow;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_issue;
    logic                  w_idx_adv;
    logic                  w_push_done;
    logic                  w_pop_done;
    logic                  w_push_accept;
    logic                  w_pop_accept;

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Pop wins arbitration: the outflow path is deadline-bound.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_issue     = 1'b0;
        w_idx_adv   = 1'b0;
        w_push_done = 1'b0;
        w_pop_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pop_pending)       w_state_nxt = S_POP;
                else if (r_push_pending) w_state_nxt = S_PUSH;
            end
            S_PUSH: begin
                if (!fifo_full) begin
                    w_wr_en   = 1'b1;
                    w_idx_adv = 1'b1;
                    if (r_idx == c_IDX_LAST) begin
                        w_push_done = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_POP: begin
                w_issue   = 1'b1;
                w_rd_en   = ~fifo_empty;
                w_idx_adv = 1'b1;
                if (r_idx == c_IDX_LAST) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_pop_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_push_accept = push_req & (~r_push_pending | w_push_done);
    assign w_pop_accept  = pop_req  & (~r_pop_pending  | w_pop_done);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_push_pending <= 1'b0;
            r_pop_pending  <= 1'b0;
            r_pop_valid    <= 1'b0;
            r_overrun      <= 1'b0;
            r_underflow    <= 1'b0;
            r_idx          <= '0;
            r_drain_cnt    <= '0;
            r_zero_mask    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_shadow[i]    <= '0;
                r_pop_words[i] <= '0;
            end
        end else begin
            if (w_push_accept) begin
                for (int i = 0; i < CHANNELS; i++)
                    r_shadow[i] <= push_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            r_push_pending <= w_push_accept | (r_push_pending & ~w_push_done);
            r_pop_pending  <= w_pop_accept  | (r_pop_pending  & ~w_pop_done);
            r_overrun      <= r_overrun
                            | (push_req & r_push_pending & ~w_push_done)
                            | (pop_req  & r_pop_pending  & ~w_pop_done);
            r_underflow    <= r_underflow | (w_issue & fifo_empty);
            r_pop_valid    <= w_pop_done;
            if (w_idx_adv) r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;
            // Words skipped on an empty FIFO return as zero, not as stale dout.
            if (r_state == S_IDLE)             r_zero_mask        <= '0;
            else if (w_issue && fifo_empty)    r_zero_mask[r_idx] <= 1'b1;
            if (r_tag_vld[READ_LATENCY-1])
                r_pop_words[r_tag_idx[READ_LATENCY-1]] <=
                    r_zero_mask[r_tag_idx[READ_LATENCY-1]] ? '0 : fifo_dout;
        end
    end

    // Read-return tags track which chunk slot each in-flight read lands in.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tag_vld[i] <= 1'b0;
                r_tag_idx[i] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_idx[0] <= r_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_idx[i] <= r_tag_idx[i-1];
            end
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
            assign pop_data[g*DATA_WIDTH +: DATA_WIDTH] = r_pop_words[g];
        end
    endgenerate

    assign fifo_wr_en = w_wr_en;
    assign fifo_rd_en = w_rd_en;
    assign fifo_din   = w_wr_en ? r_shadow[r_idx] : '0;
    assign pop_valid  = r_pop_valid;
    assign busy       = r_push_pending | r_pop_pending | (r_state != S_IDLE);
    assign overrun    = r_overrun;
    assign underflow  = r_underflow;

`ifdef FIFO_SCHED_OCCUPANCY_EN
    logic [15:0] r_occ;
    logic [15:0] r_peak;
    logic [15:0] w_occ_nxt;

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_wr_en && !w_rd_en && r_occ != 16'hFFFF)  w_occ_nxt = r_occ + 16'd1;
        else if (w_rd_en && !w_wr_en && r_occ != 16'd0) w_occ_nxt = r_occ - 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_occ  <= '0;
            r_peak <= '0;
        end else begin
            r_occ <= w_occ_nxt;
            if (w_occ_nxt > r_peak) r_peak <= w_occ_nxt;
        end
    end

    assign occupancy      = r_occ;
    assign peak_occupancy = r_peak;
`endif

endmodule
`default_nettype wire

// File: tb/tb_integrator_fifo_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : tb_integrator_fifo_scheduler
// Purpose  : Directed bench for integrator_fifo_scheduler with a queue-based
//            FIFO environment and a transaction-level reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_integrator_fifo_scheduler;

    localparam int CH = 8;
    localparam int DW = 36;
    localparam int RL = 1;
    localparam int BW = CH * DW;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          push_req = 1'b0;
    logic          pop_req = 1'b0;
    logic          fifo_full = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [BW-1:0] push_data = '0;
    logic [BW-1:0] pop_data;
    logic          pop_valid, fifo_wr_en, fifo_rd_en, busy, overrun, underflow;
    logic [DW-1:0] fifo_din;
    logic [DW-1:0] fifo_dout = '0;

    always #5 clk = ~clk;

    integrator_fifo_scheduler #(.CHANNELS(CH), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clk(clk), .resetn(resetn), .push_req(push_req), .push_data(push_data),
        .pop_req(pop_req), .pop_data(pop_data), .pop_valid(pop_valid),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .busy(busy), .overrun(overrun), .underflow(underflow)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // FIFO primitive: strobes sampled mid-cycle, applied on the next edge.
    logic [DW-1:0] fq[$];
    logic          wr_l = 1'b0, rd_l = 1'b0;
    logic [DW-1:0] din_l = '0;
    always @(negedge clk) begin
        wr_l  = fifo_wr_en;
        rd_l  = fifo_rd_en;
        din_l = fifo_din;
    end
    always @(posedge clk) begin
        if (rd_l) begin
            if (fq.size() > 0) fifo_dout <= fq.pop_front();
            else               fifo_dout <= {DW{1'b1}};
        end
        if (wr_l) fq.push_back(din_l);
        fifo_empty <= (fq.size() == 0);
    end

    // Reference model: expected write stream, FIFO contents, request bookkeeping.
    logic [DW-1:0] exp_wr_q[$];
    logic [DW-1:0] ref_q[$];
    int            pop_out = 0;
    bit            exp_ovr = 1'b0, exp_uf = 1'b0, mdl_on = 1'b0;
    int            wr_log[$];
    logic [DW-1:0] din_log[$];
    int            pv_log[$];

    always @(negedge clk) begin : compare
        logic [BW-1:0] ec;
        bit            short_f;
        if (mdl_on) begin
            chk("busy", busy, (exp_wr_q.size() > 0) || (pop_out > 0 && !pop_valid));
            chk("overrun", overrun, exp_ovr);
            chk("rd_while_empty", fifo_rd_en & fifo_empty, 1'b0);
            if (fifo_wr_en) begin
                wr_log.push_back(cyc);
                din_log.push_back(fifo_din);
                if (exp_wr_q.size() == 0) chk("unexpected_wr", fifo_wr_en, 1'b0);
                else begin
                    chk("fifo_din", fifo_din, exp_wr_q[0]);
                    ref_q.push_back(exp_wr_q.pop_front());
                end
            end
            if (pop_valid) begin
                pv_log.push_back(cyc);
                if (pop_out == 0) chk("unexpected_pop_valid", pop_valid, 1'b0);
                else begin
                    ec = '0;
                    short_f = 1'b0;
                    for (int i = 0; i < CH; i++) begin
                        if (ref_q.size() > 0) ec[i*DW +: DW] = ref_q.pop_front();
                        else short_f = 1'b1;
                    end
                    if (short_f) exp_uf = 1'b1;
                    chk("pop_data", pop_data, ec);
                    pop_out = 0;
                end
            end
            if (pop_out == 0) chk("underflow", underflow, exp_uf);
            if (push_req) begin
                if (exp_wr_q.size() == 0)
                    for (int i = 0; i < CH; i++) exp_wr_q.push_back(push_data[i*DW +: DW]);
                else exp_ovr = 1'b1;
            end
            if (pop_req) begin
                if (pop_out == 0) pop_out = 1;
                else exp_ovr = 1'b1;
            end
            if (!resetn) begin
                exp_wr_q.delete();
                pop_out = 0;
                exp_ovr = 1'b0;
                exp_uf  = 1'b0;
            end
        end
    end

    function automatic logic [BW-1:0] mk(input int base);
        logic [BW-1:0] r;
        for (int i = 0; i < CH; i++) r[i*DW +: DW] = DW'(base + i);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [BW-1:0] d);
        push_req  = 1'b1;
        push_data = d;
        tick();
        push_req  = 1'b0;
    endtask

    task automatic pop();
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
    endtask

    task automatic preload(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(DW'(base + i));
            ref_q.push_back(DW'(base + i));
        end
        tick();
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk({nm, "_idle_timeout"}, n < 200, 1'b1);
        tick();
        tick();
    endtask

    task automatic clear_logs();
        wr_log.delete();
        din_log.delete();
        pv_log.delete();
    endtask

    initial begin : stim
        int            t;
        logic [BW-1:0] e;

        repeat (3) tick();
        resetn = 1'b1;
        mdl_on = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_flags", {pop_valid, fifo_wr_en, fifo_rd_en, overrun, underflow}, 5'd0);
        chk("rst_pop_data", pop_data, '0);

        // Back-to-back pushes; the second arrives on the first burst's last write.
        clear_logs();
        t = cyc;
        push(mk(1));
        while (cyc < t + 9) tick();
        push(mk(32'h101));
        wait_idle("s1");
        chk("s1_wr_count", wr_log.size(), 16);
        chk("s1_first_wr_lat", wr_log[0] - t, 2);
        chk("s1_last_wr_lat", wr_log[7] - t, 9);
        for (int i = 0; i < CH; i++) chk("s1_din_order", din_log[i], DW'(i + 1));
        chk("s1_second_burst_lat", wr_log[8] - t, 11);
        chk("s1_overrun", overrun, 1'b0);

        // Pop both chunks back.
        clear_logs();
        t = cyc;
        pop();
        wait_idle("s2a");
        chk("s2_pop_valid_lat", pv_log[0] - t, 11);
        chk("s2_pv_count", pv_log.size(), 1);
        chk("s2_pop_data", pop_data, mk(1));
        pop();
        wait_idle("s2b");
        chk("s2_pop_data_b", pop_data, mk(32'h101));
        chk("s2_underflow", underflow, 1'b0);

        // Simultaneous push and pop with a preloaded chunk.
        preload(32'h201, 8);
        clear_logs();
        t = cyc;
        push_req  = 1'b1;
        push_data = mk(32'h301);
        pop_req   = 1'b1;
        tick();
        push_req  = 1'b0;
        pop_req   = 1'b0;
        wait_idle("s3");
        chk("s3_pop_before_wr", pv_log[0] < wr_log[0], 1'b1);
        chk("s3_pop_valid_lat", pv_log[0] - t, 11);
        chk("s3_pop_data", pop_data, mk(32'h201));
        pop();
        wait_idle("s3_drain");
        chk("s3_drain_data", pop_data, mk(32'h301));

        // Full stall of five cycles from the third word.
        clear_logs();
        t = cyc;
        push(mk(32'h401));
        while (cyc < t + 4) tick();
        fifo_full = 1'b1;
        while (cyc < t + 9) tick();
        fifo_full = 1'b0;
        wait_idle("s4");
        chk("s4_stall_gap", wr_log[2] - wr_log[1], 6);
        chk("s4_resume_lat", wr_log[2] - t, 9);
        chk("s4_last_wr_lat", wr_log[7] - t, 14);
        chk("s4_word3", din_log[2], DW'(32'h403));
        chk("s4_overrun", overrun, 1'b0);
        pop();
        wait_idle("s4_drain");
        chk("s4_drain_data", pop_data, mk(32'h401));

        // Short FIFO: six words only.
        preload(32'h501, 6);
        clear_logs();
        t = cyc;
        pop();
        wait_idle("s5");
        e = mk(32'h501);
        e[6*DW +: 2*DW] = '0;
        chk("s5_underflow", underflow, 1'b1);
        chk("s5_pop_data", pop_data, e);
        chk("s5_pop_valid_lat", pv_log[0] - t, 11);

        // Overrun, then reset mid-burst.
        clear_logs();
        t = cyc;
        push(mk(32'h601));
        push(mk(32'h701));
        while (cyc < t + 4) tick();
        chk("s6_overrun", overrun, 1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("s6_rst_busy", busy, 1'b0);
        chk("s6_rst_flags", {pop_valid, fifo_wr_en, fifo_rd_en, overrun, underflow}, 5'd0);
        chk("s6_rst_din", fifo_din, '0);
        chk("s6_rst_pop_data", pop_data, '0);
        tick();
        clear_logs();
        t = cyc;
        push(mk(1));
        wait_idle("s6_replay");
        chk("s6_first_wr_lat", wr_log[0] - t, 2);
        chk("s6_last_wr_lat", wr_log[7] - t, 9);
        chk("s6_din_last", din_log[7], DW'(8));
        pop();
        wait_idle("s6_pop");
        chk("s6_kept_word", pop_data[DW-1:0], DW'(32'h601));
        chk("s6_ch3_word", pop_data[3*DW +: DW], DW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
